iob_cache_write_channel_iob: RTL and testbench

IOB_CACHE_WRITE_CHANNEL_IOB -- requirements
Module: iob_cache_write_channel_iob

---
 rtl/iob_cache_write_channel_iob.sv | 181 ++++++++++++++++++
 tb/tb_iob_cache_write_channel_iob.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_write_channel_iob.sv
//============================================================================
// Module  : iob_cache_write_channel_iob
// Brief   : Cache write-back channel. Streams a dirty line to the back end
//           one beat at a time. Optional write-through of single front-end
//           words is built only when IOB_CACHE_WRITE_THROUGH_EN is defined.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module iob_cache_write_channel_iob #(
  parameter  int FE_ADDR_W     = 24,
  parameter  int FE_DATA_W     = 32,
  parameter  int BE_ADDR_W     = 24,
  parameter  int BE_DATA_W     = 32,
  parameter  int WORD_OFFSET_W = 2,
  localparam int BE_NBYTES     = BE_DATA_W / 8,
  localparam int BE_NBYTES_W   = $clog2(BE_NBYTES),
  localparam int LINE2BE_W     = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W),
  localparam int NBEATS        = 2 ** LINE2BE_W,
  localparam int LADDR_W       = FE_ADDR_W - (BE_NBYTES_W + LINE2BE_W)
) (
  input  logic                        clk_i,
  input  logic                        arst_n_i,
  input  logic                        write_valid_i,
  input  logic [LADDR_W-1:0]          write_addr_i,
  input  logic [BE_DATA_W*NBEATS-1:0] write_line_i,
`ifdef IOB_CACHE_WRITE_THROUGH_EN
  input  logic                                    wt_valid_i,
  input  logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0] wt_addr_i,
  input  logic [FE_DATA_W-1:0]                    wt_wdata_i,
  input  logic [FE_DATA_W/8-1:0]                  wt_wstrb_i,
`endif
  output logic                        write_ready_o,
  output logic                        write_done_o,
  output logic                        be_valid_o,
  output logic [BE_ADDR_W-1:0]        be_addr_o,
  output logic [BE_DATA_W-1:0]        be_wdata_o,
  output logic [BE_NBYTES-1:0]        be_wstrb_o,
  input  logic                        be_ack_i
);

  localparam int CNT_W = (LINE2BE_W > 0) ? LINE2BE_W : 1;
  localparam logic [BE_NBYTES-1:0] c_strb_ones = {BE_NBYTES{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LINE = 2'd1,
    S_WORD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                        r_state;
  logic [CNT_W-1:0]              r_beat;
  logic [LADDR_W-1:0]            r_addr;
  logic [BE_DATA_W*NBEATS-1:0]   r_line;
  logic [CNT_W-1:0]              w_beat_next;
  logic [BE_DATA_W-1:0]          w_beats [2**CNT_W];

  assign w_beat_next = r_beat + CNT_W'(1);

  // Beat table padded to a power of two so any counter value indexes safely.
  for (genvar gi = 0; gi < 2**CNT_W; gi++) begin : g_beat
    if (gi < NBEATS) begin : g_used
      assign w_beats[gi] = r_line[gi*BE_DATA_W +: BE_DATA_W];
    end else begin : g_pad
      assign w_beats[gi] = '0;
    end
  end

  function automatic logic [BE_ADDR_W-1:0] line_addr(input logic [LADDR_W-1:0] laddr,
                                                     input logic [CNT_W-1:0]   beat);
    logic [BE_ADDR_W-1:0] base;
    logic [BE_ADDR_W-1:0] off;
    base = BE_ADDR_W'(laddr) << (BE_NBYTES_W + LINE2BE_W);
    off  = BE_ADDR_W'(beat) << BE_NBYTES_W;
    return base | off;
  endfunction

`ifdef IOB_CACHE_WRITE_THROUGH_EN
  localparam int FE_NBYTES_W = $clog2(FE_DATA_W / 8);
  localparam int RATIO       = BE_DATA_W / FE_DATA_W;
  localparam logic [BE_ADDR_W-1:0] c_be_off_mask = BE_ADDR_W'(BE_NBYTES - 1);

  logic [BE_ADDR_W-1:0] w_wt_byte_addr;
  logic [BE_ADDR_W-1:0] w_wt_be_addr;
  logic [BE_ADDR_W-1:0] w_wt_off;
  logic [BE_NBYTES-1:0] w_wt_strb;
  logic [BE_DATA_W-1:0] w_wt_wdata;

  // The byte offset inside the back-end word selects the strobe lane.
  assign w_wt_byte_addr = BE_ADDR_W'(wt_addr_i) << FE_NBYTES_W;
  assign w_wt_be_addr   = w_wt_byte_addr & ~c_be_off_mask;
  assign w_wt_off       = w_wt_byte_addr & c_be_off_mask;
  assign w_wt_strb      = BE_NBYTES'(wt_wstrb_i) << w_wt_off;
  assign w_wt_wdata     = {RATIO{wt_wdata_i}};
`endif

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state       <= S_IDLE;
      r_beat        <= '0;
      r_addr        <= '0;
      r_line        <= '0;
      write_ready_o <= 1'b1;
      write_done_o  <= 1'b0;
      be_valid_o    <= 1'b0;
      be_addr_o     <= '0;
      be_wdata_o    <= '0;
      be_wstrb_o    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (write_valid_i) begin
            r_addr        <= write_addr_i;
            r_line        <= write_line_i;
            r_beat        <= '0;
            be_addr_o     <= line_addr(write_addr_i, '0);
            be_wdata_o    <= write_line_i[BE_DATA_W-1:0];
            be_wstrb_o    <= c_strb_ones;
            be_valid_o    <= 1'b1;
            write_ready_o <= 1'b0;
            r_state       <= S_LINE;
          end
`ifdef IOB_CACHE_WRITE_THROUGH_EN
          else if (wt_valid_i) begin
            be_addr_o     <= w_wt_be_addr;
            be_wdata_o    <= w_wt_wdata;
            be_wstrb_o    <= w_wt_strb;
            be_valid_o    <= 1'b1;
            write_ready_o <= 1'b0;
            r_state       <= S_WORD;
          end
`endif
        end

        S_LINE: begin
          if (be_ack_i) begin
            if (r_beat == CNT_W'(NBEATS - 1)) begin
              be_valid_o   <= 1'b0;
              be_wstrb_o   <= '0;
              write_done_o <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_beat     <= w_beat_next;
              be_addr_o  <= line_addr(r_addr, w_beat_next);
              be_wdata_o <= w_beats[w_beat_next];
            end
          end
        end

`ifdef IOB_CACHE_WRITE_THROUGH_EN
        S_WORD: begin
          if (be_ack_i) begin
            be_valid_o   <= 1'b0;
            be_wstrb_o   <= '0;
            write_done_o <= 1'b1;
            r_state      <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          write_done_o  <= 1'b0;
          write_ready_o <= 1'b1;
          r_state       <= S_IDLE;
        end

        default: begin
          be_valid_o    <= 1'b0;
          be_wstrb_o    <= '0;
          write_done_o  <= 1'b0;
          write_ready_o <= 1'b1;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iob_cache_write_channel_iob.sv
//============================================================================
// Module  : tb_iob_cache_write_channel_iob
// Brief   : Scoreboard bench for the cache write-back channel.
// Revision: 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iob_cache_write_channel_iob;

  localparam int FE_ADDR_W     = 24;
  localparam int FE_DATA_W     = 32;
  localparam int BE_ADDR_W     = 24;
  localparam int BE_DATA_W     = 32;
  localparam int WORD_OFFSET_W = 2;
  localparam int BE_NBYTES     = BE_DATA_W / 8;
  localparam int BE_NBYTES_W   = $clog2(BE_NBYTES);
  localparam int LINE2BE_W     = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W);
  localparam int NBEATS        = 2 ** LINE2BE_W;
  localparam int LADDR_W       = FE_ADDR_W - (BE_NBYTES_W + LINE2BE_W);
  localparam int LINE_W        = BE_DATA_W * NBEATS;

  logic                 clk_i = 1'b0;
  logic                 arst_n_i;
  logic                 write_valid_i;
  logic [LADDR_W-1:0]   write_addr_i;
  logic [LINE_W-1:0]    write_line_i;
  logic                 write_ready_o;
  logic                 write_done_o;
  logic                 be_valid_o;
  logic [BE_ADDR_W-1:0] be_addr_o;
  logic [BE_DATA_W-1:0] be_wdata_o;
  logic [BE_NBYTES-1:0] be_wstrb_o;
  logic                 be_ack_i;

  typedef struct packed {
    logic [BE_ADDR_W-1:0] addr;
    logic [BE_DATA_W-1:0] data;
    logic [BE_NBYTES-1:0] strb;
  } beat_t;

  beat_t sb[$];
  int    n_cmp     = 0;
  int    n_err     = 0;
  int    ack_delay = 0;
  int    wait_cnt  = 0;
  bit    force_ack = 1'b0;

  always #5 clk_i = ~clk_i;

  iob_cache_write_channel_iob #(
    .FE_ADDR_W(FE_ADDR_W), .FE_DATA_W(FE_DATA_W), .BE_ADDR_W(BE_ADDR_W),
    .BE_DATA_W(BE_DATA_W), .WORD_OFFSET_W(WORD_OFFSET_W)
  ) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .write_valid_i(write_valid_i), .write_addr_i(write_addr_i), .write_line_i(write_line_i),
`ifdef IOB_CACHE_WRITE_THROUGH_EN
    .wt_valid_i(1'b0), .wt_addr_i('0), .wt_wdata_i('0), .wt_wstrb_i('0),
`endif
    .write_ready_o(write_ready_o), .write_done_o(write_done_o),
    .be_valid_o(be_valid_o), .be_addr_o(be_addr_o), .be_wdata_o(be_wdata_o),
    .be_wstrb_o(be_wstrb_o), .be_ack_i(be_ack_i)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BE_ADDR_W-1:0] exp_addr(input logic [LADDR_W-1:0] la, input int b);
    return (BE_ADDR_W'(la) << (BE_NBYTES_W + LINE2BE_W)) + BE_ADDR_W'(b * BE_NBYTES);
  endfunction

  // Back-end responder: acks each beat after ack_delay idle cycles.
  initial begin
    be_ack_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (force_ack) be_ack_i = 1'b1;
      else if (be_valid_o) begin
        if (wait_cnt >= ack_delay) begin
          be_ack_i = 1'b1;
          wait_cnt = 0;
        end else begin
          be_ack_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        be_ack_i = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Every valid cycle is compared to the head entry, so waiting cycles also prove stability.
  always @(negedge clk_i) begin
    if (arst_n_i && be_valid_o) begin
      if (sb.size() == 0) check("unexpected_beat_valid", be_valid_o, 1'b0);
      else begin
        check("beat_addr", be_addr_o, sb[0].addr);
        check("beat_wdata", be_wdata_o, sb[0].data);
        check("beat_wstrb", be_wstrb_o, sb[0].strb);
        if (be_ack_i) void'(sb.pop_front());
      end
    end
  end

  task automatic push_line(input logic [LADDR_W-1:0] la, input logic [LINE_W-1:0] line);
    beat_t e;
    for (int b = 0; b < NBEATS; b++) begin
      e.addr = exp_addr(la, b);
      e.data = line[b*BE_DATA_W +: BE_DATA_W];
      e.strb = '1;
      sb.push_back(e);
    end
  endtask

  task automatic send_line(input logic [LADDR_W-1:0] la, input logic [LINE_W-1:0] line,
                           input int dly, input bit hold);
    int n;
    push_line(la, line);
    ack_delay = dly;
    @(negedge clk_i);
    check("ready_idle", write_ready_o, 1'b1);
    write_valid_i = 1'b1;
    write_addr_i  = la;
    write_line_i  = line;
    n = 0;
    while (n < 300) begin
      @(negedge clk_i);
      n++;
      if (n == 1) begin
        check("ready_busy", write_ready_o, 1'b0);
        if (hold) write_addr_i = LADDR_W'(1);
        else write_valid_i = 1'b0;
      end
      if (write_done_o) break;
    end
    write_valid_i = 1'b0;
    check("done_latency", n, NBEATS * (dly + 1) + 1);
    check("sb_drained", sb.size(), 0);
    sb.delete();
    @(negedge clk_i);
    check("done_one_cycle", write_done_o, 1'b0);
    check("ready_after_done", write_ready_o, 1'b1);
    check("valid_after_done", be_valid_o, 1'b0);
  endtask

`ifdef IOB_CACHE_WRITE_THROUGH_EN
  logic          wt2_write_valid;
  logic [19:0]   wt2_write_addr;
  logic [127:0]  wt2_write_line;
  logic          wt2_valid;
  logic [21:0]   wt2_addr;
  logic [31:0]   wt2_wdata;
  logic [3:0]    wt2_wstrb;
  logic          wt2_ready, wt2_done, wt2_be_valid, wt2_ack;
  logic [23:0]   wt2_be_addr;
  logic [63:0]   wt2_be_wdata;
  logic [7:0]    wt2_be_wstrb;

  iob_cache_write_channel_iob #(
    .FE_ADDR_W(24), .FE_DATA_W(32), .BE_ADDR_W(24), .BE_DATA_W(64), .WORD_OFFSET_W(2)
  ) dut_wt (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .write_valid_i(wt2_write_valid), .write_addr_i(wt2_write_addr), .write_line_i(wt2_write_line),
    .wt_valid_i(wt2_valid), .wt_addr_i(wt2_addr), .wt_wdata_i(wt2_wdata), .wt_wstrb_i(wt2_wstrb),
    .write_ready_o(wt2_ready), .write_done_o(wt2_done),
    .be_valid_o(wt2_be_valid), .be_addr_o(wt2_be_addr), .be_wdata_o(wt2_be_wdata),
    .be_wstrb_o(wt2_be_wstrb), .be_ack_i(wt2_ack)
  );

  task automatic run_write_through();
    @(negedge clk_i);
    wt2_valid = 1'b1; wt2_addr = 22'h000003; wt2_wdata = 32'hCAFEBABE; wt2_wstrb = 4'h3;
    @(negedge clk_i);
    wt2_valid = 1'b0;
    check("wt_valid", wt2_be_valid, 1'b1);
    check("wt_addr", wt2_be_addr, 24'h000008);
    check("wt_wdata", wt2_be_wdata, 64'hCAFEBABE_CAFEBABE);
    check("wt_wstrb", wt2_be_wstrb, 8'h30);
    wt2_ack = 1'b1;
    @(negedge clk_i);
    wt2_ack = 1'b0;
    check("wt_done", wt2_done, 1'b1);
    check("wt_valid_off", wt2_be_valid, 1'b0);
    @(negedge clk_i);
    check("wt_ready", wt2_ready, 1'b1);
    wt2_write_valid = 1'b1; wt2_write_addr = 20'h00005;
    wt2_write_line = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    wt2_valid = 1'b1;
    @(negedge clk_i);
    wt2_write_valid = 1'b0; wt2_valid = 1'b0;
    check("prio_strb", wt2_be_wstrb, 8'hFF);
    check("prio_addr", wt2_be_addr, 24'h000050);
    check("prio_wdata", wt2_be_wdata, 64'hBBBBBBBB_AAAAAAAA);
    wt2_ack = 1'b1;
    @(negedge clk_i);
    check("prio_beat1", wt2_be_addr, 24'h000058);
    @(negedge clk_i);
    wt2_ack = 1'b0;
    check("prio_done", wt2_done, 1'b1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    logic [LINE_W-1:0] rnd_line;
    write_valid_i = 1'b0;
    write_addr_i  = '0;
    write_line_i  = '0;
`ifdef IOB_CACHE_WRITE_THROUGH_EN
    wt2_write_valid = 1'b0; wt2_write_addr = '0; wt2_write_line = '0;
    wt2_valid = 1'b0; wt2_addr = '0; wt2_wdata = '0; wt2_wstrb = '0; wt2_ack = 1'b0;
`endif
    arst_n_i = 1'b1;
    #2 arst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_ready", write_ready_o, 1'b1);
    check("rst_valid", be_valid_o, 1'b0);
    check("rst_done", write_done_o, 1'b0);
    check("rst_wstrb", be_wstrb_o, '0);
    check("rst_addr", be_addr_o, '0);
    #2 arst_n_i = 1'b1;

    // Back-to-back acks, then slow acks with three wait cycles per beat.
    send_line(LADDR_W'(20'h01234), 128'h44444444_33333333_22222222_11111111, 0, 1'b0);
    send_line(LADDR_W'(20'h01234), 128'h44444444_33333333_22222222_11111111, 3, 1'b0);

    // write_valid_i held with another address during the transfer must be dropped.
    send_line(LADDR_W'(20'h01234), 128'h44444444_33333333_22222222_11111111, 0, 1'b1);
    repeat (3) begin
      @(negedge clk_i);
      check("hold_not_queued", be_valid_o, 1'b0);
    end

    // Reset during beat 2 aborts silently.
    push_line(LADDR_W'(20'h00ABC), 128'h8888_8888_7777_7777_6666_6666_5555_5555);
    ack_delay = 0;
    @(negedge clk_i);
    write_valid_i = 1'b1; write_addr_i = LADDR_W'(20'h00ABC);
    write_line_i  = 128'h8888_8888_7777_7777_6666_6666_5555_5555;
    @(negedge clk_i);
    write_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("abort_at_beat2", be_addr_o, exp_addr(LADDR_W'(20'h00ABC), 2));
    #2 arst_n_i = 1'b0;
    #1;
    check("abort_valid", be_valid_o, 1'b0);
    check("abort_ready", write_ready_o, 1'b1);
    check("abort_done", write_done_o, 1'b0);
    sb.delete();
    d0 = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (write_done_o) d0++;
    end
    #2 arst_n_i = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      if (write_done_o) d0++;
    end
    check("abort_no_done", d0, 0);
    send_line(LADDR_W'(20'h00ABC), 128'h8888_8888_7777_7777_6666_6666_5555_5555, 0, 1'b0);

    // Spurious acks while idle change nothing.
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("spur_valid", be_valid_o, 1'b0);
      check("spur_ready", write_ready_o, 1'b1);
      check("spur_done", write_done_o, 1'b0);
      check("spur_wstrb", be_wstrb_o, '0);
    end
    force_ack = 1'b0;

    for (int k = 0; k < 3; k++) begin
      rnd_line = {$urandom, $urandom, $urandom, $urandom};
      send_line(LADDR_W'($urandom), rnd_line, k, 1'b0);
    end

`ifdef IOB_CACHE_WRITE_THROUGH_EN
    run_write_through();
`endif

    repeat (2) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
